axis_rate_meter: RTL and testbench

//  Passive AXI-Stream throughput monitor. It is the measuring end of the per-microsecond

---
 rtl/axis_rate_meter.sv | 126 ++++++++++++
 tb/tb_axis_rate_meter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rate_meter.sv
// axis_rate_meter: passive AXI-Stream byte-rate monitor over CLOCKS_PER_USEC-cycle windows.
// Optional: define RATE_METER_PKT_EN to add PKTS_LAST_USEC (TLAST beats per window).
module axis_rate_meter #(
    parameter int DW              = 512,
    parameter int CLOCKS_PER_USEC = 250
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [DW/8-1:0] AXIS_TKEEP,
    input  logic            AXIS_TLAST,
    input  logic            AXIS_TVALID,
    input  logic            AXIS_TREADY,
    input  logic [31:0]     LIMIT_BYTES_PER_USEC,
    input  logic            CLEAR,
    output logic [31:0]     BYTES_LAST_USEC,
    output logic [31:0]     BYTES_PEAK,
    output logic [31:0]     OVER_LIMIT_COUNT,
    output logic            WINDOW_STROBE,
`ifdef RATE_METER_PKT_EN
    output logic [15:0]     PKTS_LAST_USEC,
`endif
    output logic            OVER_LIMIT
);

    localparam int KW = DW / 8;
    localparam int CW = $clog2(CLOCKS_PER_USEC + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLOCKS_PER_USEC);

    function automatic logic [31:0] popcount(input logic [KW-1:0] v);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < KW; i++) n = n + 32'(v[i]);
        return n;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    logic          beat;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   bytes_p1_q;
    logic          end_p1_q;
    logic [31:0]   lim_q;
    logic [31:0]   acc_q;
    logic [31:0]   total_d;
    logic          over_d;
    logic [31:0]   last_q, peak_q, ocnt_q;
    logic          strobe_q, over_q;

    always_comb begin
        beat    = AXIS_TVALID & AXIS_TREADY;
        cnt_d   = (cnt_q == CNT_MAX) ? CW'(1) : cnt_q + CW'(1);
        // The closing beat still belongs to the window being reported.
        total_d = acc_q + bytes_p1_q;
        over_d  = (lim_q != '0) && (total_d > lim_q);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q      <= CW'(1);
            bytes_p1_q <= '0;
            end_p1_q   <= 1'b0;
            lim_q      <= '0;
            acc_q      <= '0;
            last_q     <= '0;
            peak_q     <= '0;
            ocnt_q     <= '0;
            strobe_q   <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            // stage 1: beat byte count and window-end flag
            cnt_q      <= cnt_d;
            bytes_p1_q <= beat ? popcount(AXIS_TKEEP) : '0;
            end_p1_q   <= (cnt_q == CNT_MAX);
            lim_q      <= LIMIT_BYTES_PER_USEC;
            // stage 2: accumulate, publish on window end
            acc_q      <= end_p1_q ? '0 : total_d;
            strobe_q   <= end_p1_q;
            over_q     <= end_p1_q & over_d;
            if (end_p1_q) last_q <= total_d;
            if (CLEAR) begin
                peak_q <= '0;
                ocnt_q <= '0;
            end else if (end_p1_q) begin
                if (total_d > peak_q) peak_q <= total_d;
                if (over_d) ocnt_q <= sat_inc32(ocnt_q);
            end
        end
    end

    assign BYTES_LAST_USEC  = last_q;
    assign BYTES_PEAK       = peak_q;
    assign OVER_LIMIT_COUNT = ocnt_q;
    assign WINDOW_STROBE    = strobe_q;
    assign OVER_LIMIT       = over_q;

`ifdef RATE_METER_PKT_EN
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic b);
        return (a == '1) ? a : a + 16'(b);
    endfunction

    logic        pkt_p1_q;
    logic [15:0] pkt_acc_q, pkt_tot_d, pkts_q;

    always_comb pkt_tot_d = sat_add16(pkt_acc_q, pkt_p1_q);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pkt_p1_q  <= 1'b0;
            pkt_acc_q <= '0;
            pkts_q    <= '0;
        end else begin
            pkt_p1_q  <= beat & AXIS_TLAST;
            pkt_acc_q <= end_p1_q ? '0 : pkt_tot_d;
            if (end_p1_q) pkts_q <= pkt_tot_d;
        end
    end

    assign PKTS_LAST_USEC = pkts_q;
`else
    logic unused_tlast;
    assign unused_tlast = AXIS_TLAST;
`endif

endmodule

// File: tb/tb_axis_rate_meter.sv
// Bench for axis_rate_meter: random and directed stimulus, window model feeding a strobe scoreboard.
`timescale 1ns/1ps
module tb_axis_rate_meter;
    localparam int DW  = 512;
    localparam int CPU = 250;
    localparam int KW  = DW / 8;
    localparam logic [KW-1:0] FULL = '1;

    logic          clk = 1'b0;
    logic          resetn;
    logic [KW-1:0] AXIS_TKEEP;
    logic          AXIS_TLAST, AXIS_TVALID, AXIS_TREADY, CLEAR;
    logic [31:0]   LIMIT_BYTES_PER_USEC;
    logic [31:0]   BYTES_LAST_USEC, BYTES_PEAK, OVER_LIMIT_COUNT;
    logic          WINDOW_STROBE, OVER_LIMIT;
`ifdef RATE_METER_PKT_EN
    logic [15:0]   PKTS_LAST_USEC;
`endif

    always #5 clk = ~clk;

    axis_rate_meter #(.DW(DW), .CLOCKS_PER_USEC(CPU)) dut (
        .clk(clk), .resetn(resetn),
        .AXIS_TKEEP(AXIS_TKEEP), .AXIS_TLAST(AXIS_TLAST),
        .AXIS_TVALID(AXIS_TVALID), .AXIS_TREADY(AXIS_TREADY),
        .LIMIT_BYTES_PER_USEC(LIMIT_BYTES_PER_USEC), .CLEAR(CLEAR),
        .BYTES_LAST_USEC(BYTES_LAST_USEC), .BYTES_PEAK(BYTES_PEAK),
        .OVER_LIMIT_COUNT(OVER_LIMIT_COUNT), .WINDOW_STROBE(WINDOW_STROBE),
`ifdef RATE_METER_PKT_EN
        .PKTS_LAST_USEC(PKTS_LAST_USEC),
`endif
        .OVER_LIMIT(OVER_LIMIT)
    );

    typedef struct {
        int unsigned cyc;
        logic [31:0] bytes, peak, cnt;
        logic        over;
        logic [15:0] pkts;
    } exp_t;

    exp_t        expq[$];
    int          total = 0;
    int          bad = 0;
    int unsigned gcyc = 0;
    logic [31:0] cur_lim = 0;

    // model state: position within window, running sums, pending window result
    int unsigned m_pos, m_acc, m_pk, m_ptot, m_ppk, m_peak, m_cnt, m_lim;
    bit          m_pend;

    always @(posedge clk) gcyc <= gcyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, gcyc, act, exp);
        end
    endtask

    // Advances the model by one clock using the inputs about to be sampled.
    task automatic model(input bit rn, input bit v, input bit r, input logic [KW-1:0] k,
                         input bit tl, input bit clr, input logic [31:0] lim);
        exp_t e;
        if (!rn) begin
            m_pos = 0; m_acc = 0; m_pk = 0; m_pend = 0;
            m_peak = 0; m_cnt = 0; m_lim = 0;
            expq.delete();
            return;
        end
        e.over = 1'b0;
        if (m_pend) begin
            e.over = (m_lim != 0) && (m_ptot > m_lim);
            if (m_ptot > m_peak) m_peak = m_ptot;
            if (e.over && m_cnt != 32'hFFFF_FFFF) m_cnt++;
        end
        if (clr) begin
            m_peak = 0;
            m_cnt  = 0;
        end
        if (m_pend) begin
            e.cyc = gcyc + 1; e.bytes = m_ptot; e.peak = m_peak;
            e.cnt = m_cnt;    e.pkts = 16'(m_ppk);
            expq.push_back(e);
            m_pend = 0;
        end
        m_lim = lim;
        if (v && r) begin
            m_acc += $countones(k);
            if (tl && m_pk < 32'hFFFF) m_pk++;
        end
        if (m_pos == CPU - 1) begin
            m_pend = 1; m_ptot = m_acc; m_ppk = m_pk;
            m_acc = 0; m_pk = 0; m_pos = 0;
        end else begin
            m_pos++;
        end
    endtask

    task automatic step(input bit rn, input bit v, input bit r, input logic [KW-1:0] k,
                        input bit tl, input bit clr, input logic [31:0] lim);
        @(negedge clk);
        resetn = rn; AXIS_TVALID = v; AXIS_TREADY = r; AXIS_TKEEP = k;
        AXIS_TLAST = tl; CLEAR = clr; LIMIT_BYTES_PER_USEC = lim;
        model(rn, v, r, k, tl, clr, lim);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, FULL, 0, 0, cur_lim);
    endtask

    task automatic align();
        while (m_pos != 0) step(1, 0, 0, FULL, 0, 0, cur_lim);
    endtask

    task automatic run_win(input int nfull);
        for (int i = 0; i < CPU; i++) step(1, i < nfull, i < nfull, FULL, 0, 0, cur_lim);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_bytes"}, BYTES_LAST_USEC, 0);
        chk({tag, "_peak"}, BYTES_PEAK, 0);
        chk({tag, "_cnt"}, OVER_LIMIT_COUNT, 0);
        chk({tag, "_strobe"}, 32'(WINDOW_STROBE), 0);
        chk({tag, "_over"}, 32'(OVER_LIMIT), 0);
    endtask

    // scoreboard monitor
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (WINDOW_STROBE === 1'b1) begin
            if (expq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_strobe at cycle %0d: got strobe 1 expected 0", gcyc);
            end else begin
                e = expq.pop_front();
                chk("strobe_cycle", gcyc, e.cyc);
                chk("bytes_last", BYTES_LAST_USEC, e.bytes);
                chk("bytes_peak", BYTES_PEAK, e.peak);
                chk("over_count", OVER_LIMIT_COUNT, e.cnt);
                chk("over_pulse", 32'(OVER_LIMIT), 32'(e.over));
`ifdef RATE_METER_PKT_EN
                chk("pkts_last", 32'(PKTS_LAST_USEC), 32'(e.pkts));
`endif
            end
        end else begin
            chk("over_without_strobe", 32'(OVER_LIMIT), 0);
            if (expq.size() > 0 && expq[0].cyc <= gcyc) begin
                e = expq.pop_front();
                total++; bad++;
                $display("FAIL missed_strobe: got none at cycle %0d expected at %0d", gcyc, e.cyc);
            end
        end
    end

    initial begin
        resetn = 0; AXIS_TVALID = 0; AXIS_TREADY = 0; AXIS_TKEEP = '0;
        AXIS_TLAST = 0; CLEAR = 0; LIMIT_BYTES_PER_USEC = 0;
        m_pos = 0; m_acc = 0; m_pk = 0; m_ptot = 0; m_ppk = 0;
        m_peak = 0; m_cnt = 0; m_lim = 0; m_pend = 0;

        for (int i = 0; i < 3; i++) step(0, 0, 0, FULL, 0, 0, 0);
        step(1, 1, 1, FULL, 0, 0, cur_lim);
        chk_zero("reset");

        // continuous full-rate stream
        for (int i = 1; i < 3 * CPU; i++) step(1, 1, 1, FULL, 0, 0, cur_lim);
        idle(2);
        chk("full_rate_bytes", BYTES_LAST_USEC, 16000);
        chk("full_rate_peak", BYTES_PEAK, 16000);

        // 9 full beats, one 8-byte beat, stalled beats that must not count
        align();
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < CPU; i++)
                step(1, (i >= 10 && i < 19) || i == 20 || (i >= 30 && i <= 40), i < 30,
                     (i == 20) ? KW'(64'hFF) : FULL, 0, 0, cur_lim);
        idle(2);
        chk("partial_keep_bytes", BYTES_LAST_USEC, 584);

        // limit boundary: equal is not over, one beat more is
        cur_lim = 640;
        align();
        run_win(10);
        idle(2);
        chk("at_limit_bytes", BYTES_LAST_USEC, 640);
        chk("at_limit_pulse", 32'(OVER_LIMIT), 0);
        chk("at_limit_cnt", OVER_LIMIT_COUNT, 0);
        align();
        run_win(11);
        idle(2);
        chk("over_limit_bytes", BYTES_LAST_USEC, 704);
        chk("over_limit_pulse", 32'(OVER_LIMIT), 1);
        chk("over_limit_cnt", OVER_LIMIT_COUNT, 1);

        // limit zero disables the check
        cur_lim = 0;
        align();
        run_win(CPU);
        idle(2);
        chk("lim0_pulse", 32'(OVER_LIMIT), 0);
        chk("lim0_cnt", OVER_LIMIT_COUNT, 1);

        // window boundary attribution
        align();
        for (int i = 0; i < CPU; i++) step(1, i == CPU - 1, i == CPU - 1, FULL, 0, 0, cur_lim);
        step(1, 1, 1, FULL, 0, 0, cur_lim);
        idle(1);
        chk("edge_last_beat", BYTES_LAST_USEC, 64);
        idle(CPU - 2);
        idle(2);
        chk("edge_first_beat", BYTES_LAST_USEC, 64);

        // CLEAR together with an over-limit window result
        cur_lim = 640;
        align();
        run_win(11);
        step(1, 0, 0, FULL, 0, 1, cur_lim);
        idle(1);
        chk("clear_strobe", 32'(WINDOW_STROBE), 1);
        chk("clear_over_pulse", 32'(OVER_LIMIT), 1);
        chk("clear_bytes", BYTES_LAST_USEC, 704);
        chk("clear_peak", BYTES_PEAK, 0);
        chk("clear_cnt", OVER_LIMIT_COUNT, 0);

        // randomized windows
        for (int w = 0; w < 6; w++) begin
            case ($urandom_range(0, 2))
                0: cur_lim = 0;
                1: cur_lim = 5000;
                default: cur_lim = 9000;
            endcase
            for (int i = 0; i < CPU; i++)
                step(1, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                     ($urandom_range(0, 1) != 0) ? FULL : KW'({$urandom(), $urandom()}),
                     $urandom_range(0, 3) == 0, $urandom_range(0, 299) == 0, cur_lim);
        end

        // reset mid-window at count 120
        align();
        for (int i = 0; i < 119; i++) step(1, 1, 1, FULL, 1, 0, cur_lim);
        for (int i = 0; i < 3; i++) step(0, 1, 1, FULL, 1, 0, cur_lim);
        step(1, 0, 0, FULL, 0, 0, cur_lim);
        chk_zero("mid_reset");
        for (int i = 1; i < CPU; i++) begin
            if (i == 3 || i == 7 || i == 50 || i == 100 || i == 200)
                step(1, 1, 1, FULL, 1, 0, cur_lim);
            else
                step(1, (i % 13) == 0, 1, KW'({$urandom(), $urandom()}), 0, 0, cur_lim);
        end
        idle(2);
        chk("post_reset_strobe", 32'(WINDOW_STROBE), 1);
`ifdef RATE_METER_PKT_EN
        chk("post_reset_pkts", 32'(PKTS_LAST_USEC), 5);
`endif

        idle(2 * CPU);
        chk("queue_drained", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
